// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
package riscv_ctrl_pkg;

    localparam int unsigned OPC_W  = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_OP, CLS_OPIMM, CLS_JAL, CLS_ILLEGAL
    } iclass_t;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BIMM = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational instruction-class decode and legality check.
module riscv_ctrl_decode
    import riscv_ctrl_pkg::*;
#(
    parameter bit EN_JAL = 1'b1
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    output iclass_t          iclass_c,
    output logic             legal_c
);

    always_comb begin
        iclass_c = CLS_ILLEGAL;
        case (opcode)
            OPC_LOAD:   iclass_c = CLS_LOAD;
            OPC_STORE:  iclass_c = CLS_STORE;
            OPC_OP:     iclass_c = CLS_OP;
            OPC_OPIMM:  iclass_c = CLS_OPIMM;
            OPC_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) iclass_c = CLS_BRANCH;
            OPC_JAL:    if (EN_JAL) iclass_c = CLS_JAL;
            default:    iclass_c = CLS_ILLEGAL;
        endcase
    end

    assign legal_c = (iclass_c != CLS_ILLEGAL);

endmodule

// File: rtl/riscv_multicycle_ctrl_v2.sv
// Multicycle RISC-V controller with memory handshake, timeout/illegal trap
// and retired-instruction counter.
module riscv_multicycle_ctrl_v2
    import riscv_ctrl_pkg::*;
#(
    parameter bit          EN_JAL   = 1'b1,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       mem_to_reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic [1:0]       pc_source,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            state, state_nxt;
    iclass_t           iclass;
    logic              legal;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              trap_nxt;
    logic [1:0]        cause_nxt;
    logic              timeout, mem_phase, entering_mem_phase;

    riscv_ctrl_decode #(.EN_JAL(EN_JAL)) u_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .iclass_c (iclass),
        .legal_c  (legal)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_FETCH;
            wait_cnt   <= '0;
            instret    <= '0;
            trap       <= 1'b0;
            trap_cause <= TRAP_NONE;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            trap       <= trap_nxt;
            trap_cause <= cause_nxt;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    // Control outputs and next state; everything held at zero while in reset.
    always_comb begin
        alu_op        = ALU_ADD;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_REGB;
        mem_to_reg    = M2R_ALUOUT;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = PCSRC_ALU;
        retire        = 1'b0;
        state_nxt     = state;
        trap_nxt      = trap;
        cause_nxt     = trap_cause;
        timeout       = 1'b0;

        if (reset_n) begin
            case (state)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = ST_DECODE;
                    end else begin
                        timeout = (wait_cnt == WAIT_LIMIT);
                    end
                end
                ST_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_BIMM;
                    if (legal) begin
                        state_nxt = ST_EXEC;
                    end else begin
                        state_nxt = ST_TRAP;
                        cause_nxt = TRAP_ILLEGAL;
                    end
                end
                ST_EXEC: begin
                    case (iclass)
                        CLS_LOAD, CLS_STORE: begin
                            alu_src_a = SRCA_RS1;
                            alu_src_b = SRCB_IMM;
                            state_nxt = ST_MEM;
                        end
                        CLS_BRANCH: begin
                            alu_src_a     = SRCA_RS1;
                            alu_op        = ALU_SUB;
                            pc_write_cond = 1'b1;
                            pc_source     = PCSRC_ALUOUT;
                            branch_ne     = (funct3 == 3'b001);
                            retire        = 1'b1;
                            state_nxt     = ST_FETCH;
                        end
                        CLS_OP: begin
                            alu_src_a = SRCA_RS1;
                            alu_op    = ALU_FUNCT;
                            state_nxt = ST_WB;
                        end
                        CLS_OPIMM: begin
                            alu_src_a = SRCA_RS1;
                            alu_src_b = SRCB_IMM;
                            alu_op    = ALU_FUNCT;
                            state_nxt = ST_WB;
                        end
                        CLS_JAL: begin
                            reg_write  = 1'b1;
                            mem_to_reg = M2R_PC;
                            pc_write   = 1'b1;
                            pc_source  = PCSRC_ALUOUT;
                            retire     = 1'b1;
                            state_nxt  = ST_FETCH;
                        end
                        default: begin
                            state_nxt = ST_TRAP;
                            cause_nxt = TRAP_ILLEGAL;
                        end
                    endcase
                end
                ST_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (iclass == CLS_LOAD);
                    mem_write = (iclass == CLS_STORE);
                    if (mem_ready) begin
                        if (iclass == CLS_LOAD) begin
                            state_nxt = ST_WB;
                        end else begin
                            retire    = (iclass == CLS_STORE);
                            state_nxt = ST_FETCH;
                        end
                    end else begin
                        timeout = (wait_cnt == WAIT_LIMIT);
                    end
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (iclass == CLS_LOAD) ? M2R_MDR : M2R_ALUOUT;
                    retire     = 1'b1;
                    state_nxt  = ST_FETCH;
                end
                ST_TRAP: state_nxt = ST_TRAP;
                default: state_nxt = ST_FETCH;
            endcase

            if (timeout) begin
                state_nxt = ST_TRAP;
                cause_nxt = TRAP_TIMEOUT;
            end
            if (state_nxt == ST_TRAP) trap_nxt = 1'b1;
        end
    end

    // Wait counter restarts on each new memory phase and on every completed access.
    always_comb begin
        mem_phase          = (state == ST_FETCH) || (state == ST_MEM);
        entering_mem_phase = (state_nxt != state) &&
                             ((state_nxt == ST_FETCH) || (state_nxt == ST_MEM));
        wait_nxt = wait_cnt;
        if (entering_mem_phase || mem_ready) begin
            wait_nxt = '0;
        end else if (mem_phase && !timeout) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl_v2.sv
// Scoreboard bench: driver predicts one event per instruction (retire or trap),
// monitor accumulates DUT activity per instruction and compares on each event.
module tb_riscv_multicycle_ctrl_v2;
    import riscv_ctrl_pkg::*;

    localparam int MW   = 4;
    localparam int CW   = 4;
    localparam int MODN = 16;

    localparam int K_LOAD = 0, K_STORE = 1, K_BRANCH = 2, K_OP = 3;
    localparam int K_OPIMM = 4, K_JAL = 5, K_ILL = 6;

    typedef struct {
        int lat; int trapf; int cause; int iret;
        int n_rd; int n_wr; int n_iod; int n_irw; int n_pcw; int n_rw; int n_pcwc;
        int dec_a; int dec_b; int exe_a; int exe_b; int exe_op;
        int m2r; int pcsrc; int bne;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic [2:0] funct3 = 3'b000;

    logic [1:0] alu_op, alu_src_a, alu_src_b, mem_to_reg, pc_source, trap_cause;
    logic mem_read, mem_write, i_or_d, ir_write, reg_write, pc_write;
    logic pc_write_cond, branch_ne, retire, trap;
    logic [CW-1:0] instret;

    logic [1:0] nj_alu_op, nj_alu_src_a, nj_alu_src_b, nj_mem_to_reg, nj_pc_source, nj_trap_cause;
    logic nj_mem_read, nj_mem_write, nj_i_or_d, nj_ir_write, nj_reg_write, nj_pc_write;
    logic nj_pc_write_cond, nj_branch_ne, nj_retire, nj_trap;
    logic [CW-1:0] nj_instret;

    int  checks = 0;
    int  errors = 0;
    int  mcount = 0;
    bit  chk_nj = 1'b0;
    ev_t exp_q[$];

    always #5 clock = ~clock;

    riscv_multicycle_ctrl_v2 #(.EN_JAL(1'b1), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .reg_write(reg_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .pc_source(pc_source), .retire(retire),
        .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    riscv_multicycle_ctrl_v2 #(.EN_JAL(1'b0), .MAX_WAIT(MW), .CNT_W(CW)) dut_nj (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
        .mem_ready(mem_ready), .alu_op(nj_alu_op), .alu_src_a(nj_alu_src_a),
        .alu_src_b(nj_alu_src_b), .mem_to_reg(nj_mem_to_reg), .mem_read(nj_mem_read),
        .mem_write(nj_mem_write), .i_or_d(nj_i_or_d), .ir_write(nj_ir_write),
        .reg_write(nj_reg_write), .pc_write(nj_pc_write), .pc_write_cond(nj_pc_write_cond),
        .branch_ne(nj_branch_ne), .pc_source(nj_pc_source), .retire(nj_retire),
        .instret(nj_instret), .trap(nj_trap), .trap_cause(nj_trap_cause)
    );

    logic [8:0] en_vec;
    assign en_vec = {mem_read, mem_write, i_or_d, ir_write, reg_write,
                     pc_write, pc_write_cond, branch_ne, retire};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_ev(input ev_t a, input ev_t e);
        chk("latency", a.lat, e.lat);           chk("trap", a.trapf, e.trapf);
        chk("trap_cause", a.cause, e.cause);    chk("instret", a.iret, e.iret);
        chk("mem_read_cycles", a.n_rd, e.n_rd); chk("mem_write_cycles", a.n_wr, e.n_wr);
        chk("i_or_d_cycles", a.n_iod, e.n_iod); chk("ir_write_cycles", a.n_irw, e.n_irw);
        chk("pc_write_cycles", a.n_pcw, e.n_pcw); chk("reg_write_cycles", a.n_rw, e.n_rw);
        chk("pc_write_cond_cycles", a.n_pcwc, e.n_pcwc);
        chk("decode_src_a", a.dec_a, e.dec_a);  chk("decode_src_b", a.dec_b, e.dec_b);
        chk("exec_src_a", a.exe_a, e.exe_a);    chk("exec_src_b", a.exe_b, e.exe_b);
        chk("exec_alu_op", a.exe_op, e.exe_op); chk("final_mem_to_reg", a.m2r, e.m2r);
        chk("final_pc_source", a.pcsrc, e.pcsrc); chk("final_branch_ne", a.bne, e.bne);
    endtask

    function automatic bit legal_opc(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b1100011 ||
               o == 7'b0110011 || o == 7'b0010011 || o == 7'b1101111;
    endfunction

    // Reference: one instruction's outcome from wait counts and class rules.
    function automatic ev_t predict(input int cls, input logic [2:0] f, input int wf,
                                    input int wm, input int cnt);
        ev_t e;
        int  fc, mc;
        e = '{default: 0};
        e.iret = cnt % MODN;
        if (wf > MW) begin
            e.lat = MW + 2; e.trapf = 1; e.cause = 2; e.n_rd = MW + 1;
            return e;
        end
        fc = wf + 1;
        e.n_rd = fc; e.n_irw = 1; e.n_pcw = 1; e.dec_a = 2; e.dec_b = 3;
        case (cls)
            K_ILL: begin e.lat = fc + 2; e.trapf = 1; e.cause = 1; end
            K_LOAD, K_STORE: begin
                e.exe_a = 1; e.exe_b = 2;
                mc = (wm > MW) ? MW + 1 : wm + 1;
                e.n_iod = mc;
                if (cls == K_LOAD) e.n_rd += mc; else e.n_wr = mc;
                if (wm > MW) begin
                    e.lat = fc + 2 + mc + 1; e.trapf = 1; e.cause = 2;
                end else if (cls == K_STORE) begin
                    e.lat = fc + 2 + mc;
                end else begin
                    e.lat = fc + 3 + mc; e.n_rw = 1; e.m2r = 1;
                end
            end
            K_BRANCH: begin
                e.exe_a = 1; e.exe_op = 1; e.lat = fc + 2; e.n_pcwc = 1;
                e.bne = (f == 3'b001) ? 1 : 0; e.pcsrc = 1;
            end
            K_OP:    begin e.exe_a = 1; e.exe_op = 2; e.lat = fc + 3; e.n_rw = 1; end
            K_OPIMM: begin e.exe_a = 1; e.exe_b = 2; e.exe_op = 2; e.lat = fc + 3; e.n_rw = 1; end
            default: begin e.lat = fc + 2; e.n_rw = 1; e.n_pcw = 2; e.m2r = 2; e.pcsrc = 1; end
        endcase
        return e;
    endfunction

    // Monitor: per-instruction activity, popped and compared on retire or trap.
    ev_t        acc = '{default: 0};
    ev_t        exp_e;
    int         cyc = 0;
    int         ir_cyc = 0;
    bit         trapped = 1'b0;
    logic [1:0] held = 2'b00;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("reset_enables", 32'(en_vec), 0);
            acc = '{default: 0}; cyc = 0; ir_cyc = 0; trapped = 1'b0;
        end else if (trapped) begin
            chk("trap_enables", 32'(en_vec), 0);
            chk("trap_sticky", {trap, trap_cause}, {1'b1, held});
        end else begin
            cyc++;
            acc.n_rd  += int'(mem_read);  acc.n_wr  += int'(mem_write);
            acc.n_iod += int'(i_or_d);    acc.n_irw += int'(ir_write);
            acc.n_pcw += int'(pc_write);  acc.n_rw  += int'(reg_write);
            acc.n_pcwc += int'(pc_write_cond);
            if (ir_write) ir_cyc = cyc;
            if (ir_cyc != 0 && cyc == ir_cyc + 1) begin
                acc.dec_a = int'(alu_src_a); acc.dec_b = int'(alu_src_b);
            end
            if (ir_cyc != 0 && cyc == ir_cyc + 2) begin
                acc.exe_a = int'(alu_src_a); acc.exe_b = int'(alu_src_b);
                acc.exe_op = int'(alu_op);
            end
            if (retire || trap) begin
                acc.lat = cyc; acc.trapf = int'(trap); acc.cause = int'(trap_cause);
                acc.iret = int'(instret); acc.m2r = int'(mem_to_reg);
                acc.pcsrc = int'(pc_source); acc.bne = int'(branch_ne);
                chk("event_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    cmp_ev(acc, exp_e);
                end
                if (trap) begin trapped = 1'b1; held = trap_cause; end
                acc = '{default: 0}; cyc = 0; ir_cyc = 0;
            end
        end
    end

    task automatic step(input logic rn, input logic rdy);
        reset_n = rn; mem_ready = rdy;
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'($urandom));
        mcount = 0;
    endtask

    task automatic trail_trap();
        repeat (3) step(1'b1, 1'($urandom));
        do_reset();
    endtask

    // Driver: alt selects BNE for branches and opcode 1111111 for illegal.
    task automatic run_instr(input int cls, input int wf, input int wm,
                             input bit abort, input bit alt);
        logic [6:0] o;
        logic [2:0] f;
        f = 3'($urandom);
        case (cls)
            K_LOAD:   o = OPC_LOAD;
            K_STORE:  o = OPC_STORE;
            K_BRANCH: begin o = OPC_BRANCH; f = alt ? 3'b001 : 3'($urandom_range(0, 1)); end
            K_OP:     o = OPC_OP;
            K_OPIMM:  o = OPC_OPIMM;
            K_JAL:    o = OPC_JAL;
            default: begin
                if (alt) o = 7'b1111111;
                else if ($urandom_range(0, 1) == 1) begin
                    o = OPC_BRANCH; f = 3'($urandom_range(2, 7));
                end else begin
                    do o = 7'($urandom); while (legal_opc(o));
                end
            end
        endcase
        opcode = o; funct3 = f;
        if (!abort) exp_q.push_back(predict(cls, f, wf, wm, mcount));

        for (int i = 0; i < wf && i <= MW; i++) step(1'b1, 1'b0);
        if (wf > MW) begin trail_trap(); return; end
        step(1'b1, 1'b1);
        step(1'b1, 1'($urandom));
        if (chk_nj) begin
            chk("nojal_trap", 32'(nj_trap), 1);
            chk("nojal_cause", 32'(nj_trap_cause), 1);
            chk("nojal_instret", 32'(nj_instret), 0);
            chk_nj = 1'b0;
        end
        if (cls == K_ILL) begin trail_trap(); return; end
        step(1'b1, 1'($urandom));
        if (cls == K_LOAD || cls == K_STORE) begin
            if (abort) begin step(1'b1, 1'b0); do_reset(); return; end
            for (int i = 0; i < wm && i <= MW; i++) step(1'b1, 1'b0);
            if (wm > MW) begin trail_trap(); return; end
            step(1'b1, 1'b1);
            if (cls == K_LOAD) step(1'b1, 1'($urandom));
        end else if (cls == K_OP || cls == K_OPIMM) begin
            step(1'b1, 1'($urandom));
        end
        mcount++;
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 12) return $urandom_range(0, 2);
        if (r < 16) return MW;
        if (r < 19) return $urandom_range(0, MW);
        return MW + 1;
    endfunction

    initial begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        mcount = 0;
        chk("reset_instret", 32'(instret), 0);
        chk("reset_trap", 32'(trap), 0);
        chk("reset_cause", 32'(trap_cause), 0);

        chk_nj = 1'b1;
        run_instr(K_JAL, 0, 0, 1'b0, 1'b0);
        run_instr(K_LOAD, 0, 0, 1'b0, 1'b0);
        run_instr(K_BRANCH, 0, 0, 1'b0, 1'b1);
        run_instr(K_STORE, 0, 3, 1'b0, 1'b0);
        run_instr(K_LOAD, MW, MW, 1'b0, 1'b0);
        run_instr(K_OPIMM, 1, 0, 1'b0, 1'b0);
        run_instr(K_OP, MW + 1, 0, 1'b0, 1'b0);
        run_instr(K_ILL, 0, 0, 1'b0, 1'b1);
        run_instr(K_LOAD, 0, 2, 1'b1, 1'b0);
        run_instr(K_STORE, 0, MW + 1, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) run_instr(K_OP, 0, 0, 1'b0, 1'b0);
        chk("instret_wrap", 32'(instret), 32'(mcount % MODN));

        for (int n = 0; n < 300; n++) begin
            int  cls, wf, wm;
            bit  ab;
            cls = $urandom_range(0, 6);
            wf  = pick_wait();
            wm  = pick_wait();
            ab  = (cls == K_LOAD) && (wm >= 1) && (wm <= MW) && ($urandom_range(0, 9) == 0);
            run_instr(cls, wf, wm, ab, 1'b0);
        end

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
